pipe_stage_reg: RTL

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, flush and bubble insertion. Replaces the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single reusable block. Control and data fields are packed into generic buses. Every field is captured on the rising edge only, and control bits are forced to zero on any bubble so a killed instruction can never write state.

---
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, one-entry skid buffer,
// flush, and ctrl zeroing on bubbles.
//
// Ports:
//   clk                     rising-edge stage clock
//   rst_n                   synchronous reset, active-high (1 = reset)
//   in_valid / in_ready     upstream handshake
//   in_ctrl / in_data       upstream control / data bundles
//   flush                   kill held entries and the offered entry
//   out_valid / out_ready   downstream handshake
//   out_ctrl / out_data     main entry bundles (ctrl is 0 when not valid)
//   occupancy               entries held (0, 1, 2)
module pipe_stage_reg #(
  parameter int CTRL_W   = 16,
  parameter int DATA_W   = 128,
  parameter bit SKID_EN  = 1'b1,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic accept, emit;
  logic ld_main_in, ld_main_skid, ld_skid_in;
  logic clr_main_ctrl, clr_skid_ctrl;

  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  // With the skid buffer, in_ready depends only on registered state.
  // Without it, a full main entry can only take new data while draining.
  assign in_ready = SKID_EN ? ((state != TWO) & ~rst_n)
                            : ((~out_valid | out_ready) & ~rst_n);

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    ld_main_in    = 1'b0;
    ld_main_skid  = 1'b0;
    ld_skid_in    = 1'b0;
    clr_main_ctrl = 1'b0;
    clr_skid_ctrl = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nx   = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        unique case ({accept, emit})
          2'b11: ld_main_in = 1'b1;
          2'b10: begin
            if (SKID_EN) begin
              state_nx   = TWO;
              ld_skid_in = 1'b1;
            end
          end
          2'b01: begin
            state_nx      = EMPTY;
            clr_main_ctrl = 1'b1;
          end
          default: state_nx = ONE;
        endcase
      end
      TWO: begin
        if (emit) begin
          state_nx      = ONE;
          ld_main_skid  = 1'b1;
          clr_skid_ctrl = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLR_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (ld_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (ld_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (clr_main_ctrl) begin
        main_ctrl <= '0;
      end
      if (ld_skid_in) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end else if (clr_skid_ctrl) begin
        skid_ctrl <= '0;
      end
    end
  end

endmodule
